// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
//   Instruction fields and status (op, funct3, funct7b5, Zero, mem_ready)
//   flow into the controller; every strobe and mux select flows out.
//   master : controller side
//   slave  : datapath / memory side
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] ALUControl;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RISC-V core (lw, sw, R, I-ALU, beq, bne,
// jal, jalr) with a variable-latency unified memory port.
//   clk   : core clock, rising edge
//   reset : synchronous, active high; returns to FETCH, clears illegal
//   bus   : multicycle_controller_if.master (instruction fields, Zero,
//           mem_ready in; memory/regfile strobes and datapath selects out)
module multicycle_controller (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_controller_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_JALR, S_JLINK, S_BRANCH, S_ILLEGAL
    } state_t;

    state_t     state, state_next;
    logic [1:0] alu_dec;
    logic       f3_alu_ok;
    logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic       adr_src, illegal_c;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_control;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Only add/sub (000), or (110) and and (111) exist in this ALU.
    assign f3_alu_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b110) ||
                       (bus.funct3 == 3'b111);

    // funct7b5 means sub only for R-type (op[5]=1); for addi it is immediate bits.
    always_comb begin
        case (bus.funct3)
            3'b000:  alu_dec = (bus.op[5] & bus.funct7b5) ? 2'b01 : 2'b00;
            3'b110:  alu_dec = 2'b11;
            3'b111:  alu_dec = 2'b10;
            default: alu_dec = 2'b00;
        endcase
    end

    always_comb begin
        case (bus.op)
            7'b0100011: bus.ImmSrc = 2'b01;
            7'b1100011: bus.ImmSrc = 2'b10;
            7'b1101111: bus.ImmSrc = 2'b11;
            default:    bus.ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        state_next  = state;
        mem_req_c   = 1'b0;
        adr_src     = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 2'b00;
        illegal_c   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = bus.mem_ready;
                pc_write_c = bus.mem_ready;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jal target precomputed into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    7'b0000011,
                    7'b0100011: state_next = S_MEMADR;
                    7'b0110011: state_next = f3_alu_ok ? S_EXECR : S_ILLEGAL;
                    7'b0010011: state_next = f3_alu_ok ? S_EXECI : S_ILLEGAL;
                    7'b1101111: state_next = S_JAL;
                    7'b1100111: state_next = S_JALR;
                    7'b1100011: state_next = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
                    default:    state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                // PC <- target held in ALUOut; ALU forms OldPC+4 for the link.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_c = 1'b1;
                state_next = S_JLINK;
            end
            S_JLINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 2'b01;
                pc_write_c  = bus.Zero ^ bus.funct3[0];
                state_next  = S_FETCH;
            end
            S_ILLEGAL: illegal_c = 1'b1;
            default:   state_next = S_FETCH;
        endcase
    end

    // Strobes are held off combinationally while reset is high so an
    // in-flight access is dropped immediately, not one edge later.
    assign bus.mem_req    = mem_req_c   & ~reset;
    assign bus.MemWrite   = mem_write_c & ~reset;
    assign bus.IRWrite    = ir_write_c  & ~reset;
    assign bus.PCWrite    = pc_write_c  & ~reset;
    assign bus.RegWrite   = reg_write_c & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.illegal    = illegal_c;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction reference model expands
// each instruction into its expected per-cycle control words, and the bench
// replays them against the DUT with random memory latencies.
module tb_multicycle_controller;
    logic clk;
    logic reset;
    multicycle_controller_if bus ();

    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, adr, mw, irw, pcw, rw;
        logic [1:0] rs, sa, sb, imm, alu;
        logic       ill;
    } ctl_t;

    ctl_t got;
    assign got = {bus.mem_req, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                  bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                  bus.ALUControl, bus.illegal};

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];
    bit   rdy_q[$];
    logic [6:0] cur_op;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BR = 7'b1100011, OP_BAD = 7'b0001111;

    function automatic logic [1:0] imm_of(logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BR)  return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] alu_of(logic [2:0] f3, logic is_r, logic f7);
        if (f3 == 3'b110) return 2'b11;
        if (f3 == 3'b111) return 2'b10;
        return (is_r && f7) ? 2'b01 : 2'b00;
    endfunction

    function automatic ctl_t cw(bit req, bit adr, bit mw, bit irw, bit pcw, bit rw,
                                logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                logic [1:0] alu);
        ctl_t c;
        c = '{req: req, adr: adr, mw: mw, irw: irw, pcw: pcw, rw: rw, rs: rs,
              sa: sa, sb: sb, imm: imm_of(cur_op), alu: alu, ill: 1'b0};
        return c;
    endfunction

    task automatic push(ctl_t c, bit r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endtask

    // Memory-stage word repeated for each wait cycle, then once with ready.
    task automatic mem_stage(ctl_t c, int waits);
        for (int i = 0; i < waits; i++) push(c, 1'b0);
        push(c, 1'b1);
    endtask

    task automatic plan(logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                        int fw, int mwait);
        cur_op = o;
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        for (int i = 0; i < fw; i++) push(cw(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00), 1'b0);
        push(cw(1,0,0,1,1,0, 2'b10,2'b00,2'b10,2'b00), 1'b1);
        push(cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00), 1'($urandom));
        if (o == OP_LW || o == OP_SW) begin
            push(cw(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00), 1'($urandom));
            if (o == OP_LW) begin
                mem_stage(cw(1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00), mwait);
                push(cw(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00), 1'($urandom));
            end else begin
                mem_stage(cw(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00), mwait);
            end
        end else if (o == OP_R || o == OP_I) begin
            push(cw(0,0,0,0,0,0, 2'b00,2'b10,(o == OP_I) ? 2'b01 : 2'b00,
                    alu_of(f3, o == OP_R, f7)), 1'($urandom));
            push(cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00), 1'($urandom));
        end else if (o == OP_JAL) begin
            push(cw(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00), 1'($urandom));
            push(cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00), 1'($urandom));
        end else if (o == OP_JALR) begin
            push(cw(0,0,0,0,1,0, 2'b10,2'b10,2'b01,2'b00), 1'($urandom));
            push(cw(0,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00), 1'($urandom));
            push(cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00), 1'($urandom));
        end else if (o == OP_BR) begin
            push(cw(0,0,0,0,z ^ f3[0],0, 2'b00,2'b10,2'b00,2'b01), 1'($urandom));
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic run(string tag);
        int n = 0;
        while (exp_q.size() > 0) begin
            ctl_t e;
            e = exp_q.pop_front();
            bus.mem_ready = rdy_q.pop_front();
            #1;
            checks++;
            assert (got === e) else begin
                errors++;
                $error("FAIL %s step %0d got %h exp %h", tag, n, got, e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_strobes_off(string tag);
        checks++;
        assert ({bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite} === 5'b0)
        else begin
            errors++;
            $error("FAIL %s got %b exp 00000", tag,
                   {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite});
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.op = OP_LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        cur_op = OP_LW;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_strobes_off("reset_hold");
        end
        reset = 1'b0;

        plan(OP_LW, 3'b010, 0, 0, 0, 0);   run("lw");
        plan(OP_SW, 3'b010, 0, 0, 0, 2);   run("sw_wait2");
        plan(OP_R,  3'b000, 1, 0, 0, 0);   run("sub");
        plan(OP_I,  3'b000, 1, 0, 0, 0);   run("addi_f7");
        plan(OP_BR, 3'b000, 0, 1, 0, 0);   run("beq_taken");
        plan(OP_BR, 3'b001, 0, 1, 0, 0);   run("bne_not_taken");
        plan(OP_JALR, 3'b000, 0, 0, 0, 0); run("jalr");
        plan(OP_JAL, 3'b000, 0, 0, 2, 0);  run("jal_fetchwait");

        for (int k = 0; k < 40; k++) begin
            logic [6:0] o;
            logic [2:0] f3;
            int         sel;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: o = OP_LW;   1: o = OP_SW;   2: o = OP_R;    3: o = OP_I;
                4: o = OP_JAL;  5: o = OP_JALR; default: o = OP_BR;
            endcase
            f3 = 3'($urandom);
            if (o == OP_R || o == OP_I) begin
                sel = int'($urandom_range(0, 2));
                f3 = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b110 : 3'b111;
            end else if (o == OP_BR) begin
                f3 = {2'b00, 1'($urandom)};
            end
            plan(o, f3, 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run("random");
        end

        // Unsupported opcode: absorbed in ILLEGAL with all strobes off.
        plan(OP_BAD, 3'b000, 0, 0, 1, 0);
        void'(exp_q.pop_back());
        void'(rdy_q.pop_back());
        push(cw(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00), 1'b1);
        for (int i = 0; i < 10; i++) begin
            ctl_t c;
            c = cw(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00);
            c.ill = 1'b1;
            push(c, 1'($urandom));
        end
        run("illegal_sticky");
        reset = 1'b1;
        #1;
        check_strobes_off("reset_in_illegal");
        @(negedge clk);
        reset = 1'b0;
        plan(OP_LW, 3'b010, 0, 0, 0, 0);   run("lw_after_illegal");

        // Reset during a MEMREAD wait abandons the load.
        plan(OP_LW, 3'b010, 0, 0, 0, 1);
        while (exp_q.size() > 4) begin
            void'(exp_q.pop_back());
            void'(rdy_q.pop_back());
        end
        run("lw_to_memread");
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        assert (got === cw(0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00)) else begin
            errors++;
            $error("FAIL reset_in_memread got %h exp %h", got,
                   cw(0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00));
        end
        @(negedge clk);
        reset = 1'b0;
        plan(OP_R, 3'b110, 0, 0, 1, 0);    run("r_after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
